serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller. Sequences a single one-bit full-adder cell
//   LSB-first over two WIDTH-bit operands, one bit per cycle, with a carry

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell, reused once per bit by the serial adder.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic sum_o,
  output logic co_o
);

  assign sum_o = a_i ^ b_i ^ ci_i;
  assign co_o  = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks LSB-first over WIDTH bits,
// with a carry flip-flop between bits and a start/ready/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_shifted;
  logic             carry;
  logic             fa_sum;
  logic             fa_co;
  logic             accept;
  logic             run;
  logic             last_bit;

  assign accept   = (state == ST_IDLE) && start_i;
  assign run      = (state == ST_RUN);
  assign last_bit = run && (count == LAST);

  full_adder_bit u_fa (
    .a_i   (a_sh[0]),
    .b_i   (b_sh[0]),
    .ci_i  (carry),
    .sum_o (fa_sum),
    .co_o  (fa_co)
  );

  // Only WIDTH-1 partial sum bits need storage: the last bit comes straight
  // from the adder on the final RUN cycle.
  if (WIDTH == 1) begin : g_w1
    assign sum_shifted = fa_sum;
  end else begin : g_wn
    logic [WIDTH-2:0] partial;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        partial <= '0;
      end else if (run) begin
        partial <= sum_shifted[WIDTH-1:1];
      end
    end

    assign sum_shifted = {fa_sum, partial};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (count == LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands are captured only on accept, so later input activity is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum_o <= '0;
      co_o  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_i;
      b_sh  <= b_i;
      carry <= ci_i;
      count <= '0;
    end else if (run) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_co;
      count <= count + 1'b1;
      if (last_bit) begin
        sum_o <= sum_shifted;
        co_o  <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ci8 = 1'b0;
  logic       ready8, busy8, done8, co8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       ci1 = 1'b0;
  logic       ready1, busy1, done1, co1;
  logic       sum1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .ci_i(ci8),
    .ready_o(ready8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .co_o(co8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1), .ci_i(ci1),
    .ready_o(ready1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .co_o(co1)
  );

  // Runs one operation on either DUT. lat counts posedges from the accept edge
  // (inclusive) through the edge that opens the done cycle.
  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, output logic [7:0] s, output logic co,
                        output int lat, output int busy_n, output logic [8:0] held,
                        output bit timed_out);
    int edges;
    @(negedge clk);
    if (w1) begin start1 = 1'b1; a1 = a[0]; b1 = b[0]; ci1 = ci; end
    else    begin start8 = 1'b1; a8 = a;    b8 = b;    ci8 = ci; end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx;
    start8 = 1'b0; a8 = 'x;   b8 = 'x;   ci8 = 1'bx;
    edges = 1; busy_n = 0; timed_out = 1'b1; s = '0; co = 1'b0; lat = 0;
    held = w1 ? {co1, 7'b0, sum1} : {co8, sum8};
    for (int n = 0; n < 40; n++) begin
      if (w1 ? busy1 : busy8) busy_n++;
      if (w1 ? done1 : done8) begin
        s = w1 ? {7'b0, sum1} : sum8;
        co = w1 ? co1 : co8;
        lat = edges;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      edges++;
    end
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (ready8 !== 1'b1) $display("[TB] FAIL reset_ready got %b exp 1", ready8); else passed++;
    checks++; if (busy8 !== 1'b0) $display("[TB] FAIL reset_busy got %b exp 0", busy8); else passed++;
    checks++; if (done8 !== 1'b0) $display("[TB] FAIL reset_done got %b exp 0", done8); else passed++;
    checks++; if (sum8 !== 8'h00) $display("[TB] FAIL reset_sum got %h exp 00", sum8); else passed++;
    checks++; if (co8 !== 1'b0) $display("[TB] FAIL reset_co got %b exp 0", co8); else passed++;
    checks++; if (ready1 !== 1'b1) $display("[TB] FAIL reset_ready_w1 got %b exp 1", ready1); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    logic [7:0] s; logic co; int lat, busy_n; logic [8:0] held; bit to;
    run_op(1'b0, 8'h35, 8'h4A, 1'b0, s, co, lat, busy_n, held, to);
    checks++; if (to) $display("[TB] FAIL basic_timeout no done_o within bound"); else passed++;
    checks++; if (s !== 8'h7F) $display("[TB] FAIL basic_sum got %h exp 7f", s); else passed++;
    checks++; if (co !== 1'b0) $display("[TB] FAIL basic_co got %b exp 0", co); else passed++;
    checks++; if (lat !== 9) $display("[TB] FAIL basic_latency got %0d exp 9", lat); else passed++;
    checks++; if (busy_n !== 8) $display("[TB] FAIL basic_busy_cycles got %0d exp 8", busy_n); else passed++;
  endtask

  task automatic test_carry();
    logic [7:0] s; logic co; int lat, busy_n; logic [8:0] held; bit to;
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, s, co, lat, busy_n, held, to);
    checks++; if (s !== 8'h00 || to) $display("[TB] FAIL carry1_sum got %h exp 00", s); else passed++;
    checks++; if (co !== 1'b1) $display("[TB] FAIL carry1_co got %b exp 1", co); else passed++;
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1, s, co, lat, busy_n, held, to);
    checks++; if (held !== 9'h100) $display("[TB] FAIL held_during_run got %h exp 100", held); else passed++;
    checks++; if (s !== 8'hFF || to) $display("[TB] FAIL carry2_sum got %h exp ff", s); else passed++;
    checks++; if (co !== 1'b1) $display("[TB] FAIL carry2_co got %b exp 1", co); else passed++;
  endtask

  task automatic test_back_to_back();
    int done_idx[2];
    logic [7:0] done_sum[2];
    int ndone = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; ci8 = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 40 && ndone < 2; n++) begin
      @(negedge clk);
      a8 = 8'h20;
      if (done8) begin
        done_idx[ndone] = n;
        done_sum[ndone] = sum8;
        ndone++;
      end
    end
    start8 = 1'b0; a8 = '0; b8 = '0;
    checks++; if (ndone !== 2) $display("[TB] FAIL b2b_done_count got %0d exp 2", ndone); else passed++;
    checks++; if (done_sum[0] !== 8'h11) $display("[TB] FAIL b2b_first_sum got %h exp 11", done_sum[0]); else passed++;
    checks++; if (done_sum[1] !== 8'h21) $display("[TB] FAIL b2b_second_sum got %h exp 21", done_sum[1]); else passed++;
    checks++;
    if (done_idx[1] - done_idx[0] !== 10)
      $display("[TB] FAIL b2b_spacing got %0d exp 10", done_idx[1] - done_idx[0]);
    else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] s; logic co; int lat, busy_n; logic [8:0] held; bit to;
    int dones = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'hF0; ci8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy8 !== 1'b1) $display("[TB] FAIL abort_busy_before got %b exp 1", busy8); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready8 !== 1'b1) $display("[TB] FAIL abort_ready got %b exp 1", ready8); else passed++;
    checks++; if (busy8 !== 1'b0) $display("[TB] FAIL abort_busy got %b exp 0", busy8); else passed++;
    checks++; if (sum8 !== 8'h00) $display("[TB] FAIL abort_sum got %h exp 00", sum8); else passed++;
    checks++; if (co8 !== 1'b0) $display("[TB] FAIL abort_co got %b exp 0", co8); else passed++;
    for (int n = 0; n < 12; n++) begin
      if (done8) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) $display("[TB] FAIL abort_no_done got %0d pulses exp 0", dones); else passed++;
    run_op(1'b0, 8'h5A, 8'hC3, 1'b1, s, co, lat, busy_n, held, to);
    checks++; if (s !== 8'h1E || to) $display("[TB] FAIL after_abort_sum got %h exp 1e", s); else passed++;
    checks++; if (co !== 1'b1) $display("[TB] FAIL after_abort_co got %b exp 1", co); else passed++;
  endtask

  task automatic test_width1();
    logic [7:0] s; logic co; int lat, busy_n; logic [8:0] held; bit to;
    logic [1:0] exp_fa;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      exp_fa = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      run_op(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], s, co, lat, busy_n, held, to);
      checks++;
      if ({co, s[0]} !== exp_fa || to)
        $display("[TB] FAIL w1_result a=%b b=%b ci=%b got %b%b exp %b", v[2], v[1], v[0], co, s[0], exp_fa);
      else passed++;
      checks++;
      if (lat !== 2) $display("[TB] FAIL w1_latency got %0d exp 2", lat); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry();
    test_back_to_back();
    test_abort();
    test_width1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
